// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode/state types and helpers for the sequential ALU.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      OR  = 3'b010,
      AND = 3'b011,
      SHL = 3'b100,
      SHR = 3'b101,
      ROL = 3'b110,
      ASR = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_state_e;

   // True for the four opcodes that run through the bit-serial shifter.
   function automatic logic is_shift(input logic [2:0] op);
      return (op == SHL) || (op == SHR) || (op == ROL) || (op == ASR);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand-issue and result handshake bundle for seq_alu.
// master = producer/consumer side, slave = the ALU itself.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             zero;
   logic             neg;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, result, cout, zero, neg, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, result, cout, zero, neg, ovf
   );
endinterface

// File: rtl/seq_alu_alu_core.sv
// alu_core: single-cycle combinational datapath for ADD/SUB/OR/AND.
// Shift opcodes produce zeros here; the top level handles them serially.
// The signed-overflow term exists only when SEQ_ALU_FLAGS_EN is defined.
module alu_core
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   // One extra bit carries the carry (ADD) or the borrow sign (SUB).
   assign sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign diff_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

   // Select result and carry/borrow for the non-shift opcodes.
   always_comb begin
      result = {WIDTH{1'b0}};
      cout   = 1'b0;
      case (op)
         ADD: begin
            result = sum_s[WIDTH-1:0];
            cout   = sum_s[WIDTH];
         end
         SUB: begin
            result = diff_s[WIDTH-1:0];
            cout   = diff_s[WIDTH];
         end
         OR: begin
            result = a | b;
            cout   = 1'b0;
         end
         AND: begin
            result = a & b;
            cout   = 1'b0;
         end
         default: begin
            result = {WIDTH{1'b0}};
            cout   = 1'b0;
         end
      endcase
   end

`ifdef SEQ_ALU_FLAGS_EN
   // Signed overflow from operand and result sign bits.
   always_comb begin
      ovf = 1'b0;
      case (op)
         ADD:     ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         SUB:     ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
         default: ovf = 1'b0;
      endcase
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU. ADD/SUB/OR/AND complete in one cycle;
// SHL/SHR/ROL/ASR shift one bit per cycle. Result and flags are registered
// and held until the consumer takes them.
// Build option: define SEQ_ALU_FLAGS_EN to compute zero/neg/ovf; otherwise
// those ports are tied low.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst,
   seq_alu_if.slave   bus
);

   localparam logic [1:0]     S_IDLE  = IDLE;
   localparam logic [1:0]     S_SHIFT = SHIFT;
   localparam logic [1:0]     S_DONE  = DONE;
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [WIDTH-1:0] work_r;
   logic [WIDTH-1:0] work_s;
   logic [SHW-1:0]   cnt_r;
   logic [SHW-1:0]   cnt_s;
   logic [2:0]       op_r;
   logic [2:0]       op_s;

   logic [WIDTH-1:0] result_r;
   logic             cout_r;
   logic             out_valid_r;

   logic             in_ready_s;
   logic             accept_s;
   logic [SHW-1:0]   amt_s;
   logic             load_s;
   logic [WIDTH-1:0] res_s;
   logic             cout_s;
   logic             ovf_s;

   logic [WIDTH-1:0] step_val_s;
   logic             step_bit_s;

   logic [WIDTH-1:0] core_res_s;
   logic             core_cout_s;
   logic             core_ovf_s;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (bus.a),
      .b      (bus.b),
      .cin    (bus.cin),
      .op     (bus.op),
      .result (core_res_s),
      .cout   (core_cout_s),
      .ovf    (core_ovf_s)
   );

   // Ready when idle, or when the held result leaves this very cycle.
   always_comb begin
      if (rst) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = (state_r == S_IDLE) || ((state_r == S_DONE) && bus.out_ready);
      end
   end

   assign accept_s = bus.in_valid && in_ready_s;
   assign amt_s    = bus.b[SHW-1:0];

   // One shift step of the working register; step_bit_s is the bit leaving it.
   always_comb begin
      step_val_s = work_r;
      step_bit_s = 1'b0;
      case (op_r)
         SHL: begin
            step_val_s = {work_r[WIDTH-2:0], 1'b0};
            step_bit_s = work_r[WIDTH-1];
         end
         SHR: begin
            step_val_s = {1'b0, work_r[WIDTH-1:1]};
            step_bit_s = work_r[0];
         end
         ROL: begin
            step_val_s = {work_r[WIDTH-2:0], work_r[WIDTH-1]};
            step_bit_s = work_r[WIDTH-1];
         end
         ASR: begin
            step_val_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
            step_bit_s = work_r[0];
         end
         default: begin
            step_val_s = work_r;
            step_bit_s = 1'b0;
         end
      endcase
   end

   // Next-state and output-load decision for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_s = state_r;
      work_s  = work_r;
      cnt_s   = cnt_r;
      op_s    = op_r;
      load_s  = 1'b0;
      res_s   = result_r;
      cout_s  = cout_r;
      ovf_s   = 1'b0;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               if (is_shift(bus.op) && (amt_s != CNT_ZERO)) begin
                  state_s = S_SHIFT;
                  work_s  = bus.a;
                  cnt_s   = amt_s;
                  op_s    = bus.op;
               end else if (is_shift(bus.op)) begin
                  // Zero-length shift passes a straight through.
                  state_s = S_DONE;
                  load_s  = 1'b1;
                  res_s   = bus.a;
                  cout_s  = 1'b0;
               end else begin
                  state_s = S_DONE;
                  load_s  = 1'b1;
                  res_s   = core_res_s;
                  cout_s  = core_cout_s;
                  ovf_s   = core_ovf_s;
               end
            end else if ((state_r == S_DONE) && bus.out_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = state_r;
            end
         end
         S_SHIFT: begin
            work_s = step_val_s;
            cnt_s  = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               state_s = S_DONE;
               load_s  = 1'b1;
               res_s   = step_val_s;
               cout_s  = step_bit_s;
            end else begin
               state_s = S_SHIFT;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Sequencer state and shifter working registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         work_r  <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         op_r    <= 3'b000;
      end else begin
         state_r <= state_s;
         work_r  <= work_s;
         cnt_r   <= cnt_s;
         op_r    <= op_s;
      end
   end

   // Output registers: loaded only when an operation completes, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
      end else begin
         out_valid_r <= (state_s == S_DONE);
         if (load_s) begin
            result_r <= res_s;
            cout_r   <= cout_s;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.cout      = cout_r;

`ifdef SEQ_ALU_FLAGS_EN
   logic zero_r;
   logic neg_r;
   logic ovf_r;

   // Status flags captured alongside the result they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_r <= 1'b0;
         neg_r  <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         if (load_s) begin
            zero_r <= (res_s == {WIDTH{1'b0}});
            neg_r  <= res_s[WIDTH-1];
            ovf_r  <= ovf_s;
         end
      end
   end

   assign bus.zero = zero_r;
   assign bus.neg  = neg_r;
   assign bus.ovf  = ovf_r;
`else
   logic unused_ovf_s;
   assign unused_ovf_s = ovf_s;
   assign bus.zero     = 1'b0;
   assign bus.neg      = 1'b0;
   assign bus.ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scenarios plus randomized traffic for seq_alu (WIDTH=8),
// checked against an arithmetic reference model and a result queue.
module tb_seq_alu;
   import seq_alu_pkg::*;

`ifdef SEQ_ALU_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   typedef struct {
      logic [7:0] res;
      logic       cout;
      logic       zero;
      logic       neg;
      logic       ovf;
      int         n;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   last_acc = 1'b0;
   exp_t exp_q[$];

   bit         have = 1'b0;
   logic [2:0] p_op;
   logic [7:0] p_a;
   logic [7:0] p_b;
   logic       p_c;

   seq_alu_if #(.WIDTH(8)) bus ();

   seq_alu #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: result/flags straight from the opcode definitions.
   function automatic exp_t ref_calc(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic ci);
      exp_t e;
      int ai, bi, sa, sb, n, r;
      ai = int'(a);
      bi = int'(b);
      sa = (ai >= 128) ? ai - 256 : ai;
      sb = (bi >= 128) ? bi - 256 : bi;
      n  = bi % 8;
      e.ovf = 1'b0;
      e.n   = 0;
      r = 0;
      case (op)
         3'd0: begin
            r = ai + bi + int'(ci);
            e.cout = (r > 255);
            e.ovf  = ((sa + sb + int'(ci)) > 127) || ((sa + sb + int'(ci)) < -128);
         end
         3'd1: begin
            r = ai - bi - int'(ci);
            e.cout = (ai < bi + int'(ci));
            e.ovf  = (a[7] != b[7]) && (((r & 255) >= 128) != (a[7] == 1'b1));
         end
         3'd2: begin r = ai | bi; e.cout = 1'b0; end
         3'd3: begin r = ai & bi; e.cout = 1'b0; end
         3'd4: begin r = ai << n; e.cout = (n != 0) && (((ai >> (8 - n)) & 1) == 1); e.n = n; end
         3'd5: begin r = ai >> n; e.cout = (n != 0) && (((ai >> (n - 1)) & 1) == 1); e.n = n; end
         3'd6: begin
            r = (ai << n) | (ai >> (8 - n));
            e.cout = (n != 0) && ((r & 1) == 1);
            e.n = n;
         end
         default: begin
            r = sa >>> n;
            e.cout = (n != 0) && (((ai >> (n - 1)) & 1) == 1);
            e.n = n;
         end
      endcase
      e.res  = 8'(r & 255);
      e.zero = FLAGS_ON && (e.res == 8'h00);
      e.neg  = FLAGS_ON && e.res[7];
      e.ovf  = FLAGS_ON && e.ovf;
      e.due  = 0;
      return e;
   endfunction

   // One cycle: check outputs at the falling edge, drive inputs, check in_ready.
   task automatic step(input logic iv, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic ordy);
      logic exp_ov;
      logic exp_ir;
      exp_t e;
      @(negedge clk);
      exp_ov = (exp_q.size() != 0) && (cyc >= exp_q[0].due);
      check_value("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) begin
         check_value("result", 32'(bus.result), 32'(exp_q[0].res));
         check_value("cout",   32'(bus.cout),   32'(exp_q[0].cout));
         check_value("zero",   32'(bus.zero),   32'(exp_q[0].zero));
         check_value("neg",    32'(bus.neg),    32'(exp_q[0].neg));
         check_value("ovf",    32'(bus.ovf),    32'(exp_q[0].ovf));
      end
      bus.in_valid  = iv;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.cin       = ci;
      bus.out_ready = ordy;
      #1;
      exp_ir = (exp_q.size() == 0) || (exp_ov && ordy);
      check_value("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      if (exp_ov && ordy) void'(exp_q.pop_front());
      last_acc = iv && exp_ir;
      if (last_acc) begin
         e = ref_calc(op, a, b, ci);
         e.due = cyc + 1 + e.n;
         exp_q.push_back(e);
      end
      cyc++;
   endtask

   // Literal check of the result currently presented (test-plan values).
   task automatic peek(input string tag, input logic [7:0] res, input logic co,
                       input logic z, input logic ng, input logic ov);
      check_value({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_value({tag, "_result"}, 32'(bus.result), 32'(res));
      check_value({tag, "_cout"}, 32'(bus.cout), 32'(co));
      check_value({tag, "_zero"}, 32'(bus.zero), 32'(FLAGS_ON && z));
      check_value({tag, "_neg"}, 32'(bus.neg), 32'(FLAGS_ON && ng));
      check_value({tag, "_ovf"}, 32'(bus.ovf), 32'(FLAGS_ON && ov));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check_value("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_value("rst_result", 32'(bus.result), 32'd0);
      check_value("rst_cout", 32'(bus.cout), 32'd0);
      check_value("rst_flags", 32'({bus.zero, bus.neg, bus.ovf}), 32'd0);
      rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = 8'h00;
      bus.b         = 8'h00;
      bus.cin       = 1'b0;
      bus.op        = 3'b000;
      do_reset();

      // ADD overflow into sign bit.
      step(1'b1, ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      peek("tp_add", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

      // SUB with borrow-in, then a plain SUB.
      step(1'b1, SUB, 8'h05, 8'h05, 1'b1, 1'b1);
      step(1'b1, SUB, 8'h10, 8'h01, 1'b0, 1'b1);
      peek("tp_sub1", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, SUB, 8'h00, 8'h00, 1'b0, 1'b1);
      peek("tp_sub2", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

      // ASR by 3: busy for 3 cycles, result 4 cycles after accept.
      step(1'b1, ASR, 8'h90, 8'h03, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, OR, 8'h11, 8'h22, 1'b0, 1'b0);
      peek("tp_asr", 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, OR, 8'h00, 8'h00, 1'b0, 1'b1);

      // ROL by 1 wraps the top bit; then hold the result with out_ready low.
      step(1'b1, ROL, 8'h81, 8'h01, 1'b0, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b0);
      peek("tp_rol", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, SUB, 8'hAA, 8'h55, 1'b1, 1'b0);
      peek("tp_hold", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, AND, 8'hF0, 8'h3C, 1'b0, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      peek("tp_and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back ADDs at full rate.
      for (int i = 0; i < 6; i++)
         step(1'b1, ADD, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      // Shift by 0 (upper amount bits ignored).
      step(1'b1, SHL, 8'hA5, 8'hF8, 1'b1, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      peek("tp_sh0", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of SHL by 7: no result may appear.
      step(1'b1, SHL, 8'h01, 8'h07, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      step(1'b1, SHR, 8'hC3, 8'h02, 1'b0, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      peek("tp_post_rst", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with producer gaps and consumer stalls.
      for (int i = 0; i < 600; i++) begin
         if (!have && ($urandom_range(0, 3) != 0)) begin
            have = 1'b1;
            p_op = 3'($urandom_range(0, 7));
            p_a  = 8'($urandom);
            p_b  = 8'($urandom);
            p_c  = 1'($urandom);
         end
         if (have)
            step(1'b1, p_op, p_a, p_b, p_c, ($urandom_range(0, 3) != 0));
         else
            step(1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0));
         if (last_acc) have = 1'b0;
      end
      for (int i = 0; i < 10; i++) step(1'b0, ADD, 8'h00, 8'h00, 1'b0, 1'b1);
      check_value("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
